// File: rtl/capture_buffer_if.sv
// Sample stream into the capture buffer and the host readout handshake out of it.
interface capture_buffer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] sample_in;
  logic              sample_stb;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output sample_in, sample_stb, rd_req,
    input  rd_data, rd_valid
  );

  modport slave (
    input  sample_in, sample_stb, rd_req,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/capture_buffer.sv
// Pre-trigger ring buffer with level/edge trigger; freezes one DEPTH-sample frame
// and plays it back oldest-first through a request/valid readout.
//
// state | meaning
// IDLE  | no capture armed; arm accepted
// PRE   | filling the p pre-trigger samples
// WAIT  | ring running, looking for the trigger on each stored sample
// POST  | storing the DEPTH-1-p post-trigger samples
// DONE  | frame frozen; readout active; arm accepted
module capture_buffer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              adc_clk,
  input  logic              reset,
  capture_buffer_if.slave   bus,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  input  logic [ADDR_W-1:0] pre_count,
  output logic              busy,
  output logic              triggered,
  output logic              done
);

  localparam int                DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] prev_sample;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] p_eff;
  logic [ADDR_W-1:0] pre_rem;
  logic [ADDR_W-1:0] post_rem;
  logic [ADDR_W-1:0] start_ptr;
  logic [ADDR_W-1:0] start_calc;
  logic              prev_valid;
  logic              rd_pend;

  logic arm_ok;
  logic we;
  logic edge_hit;
  logic trig_hit;
  logic rd_ok;

  assign edge_hit = trig_rising
                  ? (prev_sample < trig_level) && (bus.sample_in >= trig_level)
                  : (prev_sample > trig_level) && (bus.sample_in <= trig_level);

  // Oldest sample of the frame, relative to the trigger sample being written now
  assign start_calc = wr_ptr - p_eff;

  assign busy = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign done = (state == S_DONE);

  always_ff @(posedge adc_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    arm_ok   = 1'b0;
    we       = 1'b0;
    trig_hit = 1'b0;
    rd_ok    = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm) begin
          arm_ok   = 1'b1;
          state_nx = (pre_count == '0) ? S_WAIT : S_PRE;
        end
      end
      S_PRE: begin
        we = bus.sample_stb;
        if (we && (pre_rem == ADDR_W'(1))) state_nx = S_WAIT;
      end
      S_WAIT: begin
        we       = bus.sample_stb;
        trig_hit = we && (force_trig || (prev_valid && edge_hit));
        if (trig_hit) state_nx = (p_eff == PTR_MAX) ? S_DONE : S_POST;
      end
      S_POST: begin
        we = bus.sample_stb;
        if (we && (post_rem == ADDR_W'(1))) state_nx = S_DONE;
      end
      S_DONE: begin
        if (arm) begin
          arm_ok   = 1'b1;
          state_nx = (pre_count == '0) ? S_WAIT : S_PRE;
        end else begin
          rd_ok = bus.rd_req && !rd_pend;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      p_eff        <= '0;
      pre_rem      <= '0;
      post_rem     <= '0;
      start_ptr    <= '0;
      prev_sample  <= '0;
      prev_valid   <= 1'b0;
      triggered    <= 1'b0;
      rd_pend      <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      rd_pend      <= rd_ok;
      bus.rd_valid <= rd_pend;
      if (rd_pend) bus.rd_data <= ram_q;

      // pre_count is ADDR_W wide, so it can never exceed DEPTH-1: latching it is the clamp
      if (arm_ok) begin
        wr_ptr     <= '0;
        p_eff      <= pre_count;
        pre_rem    <= pre_count;
        prev_valid <= 1'b0;
        triggered  <= 1'b0;
      end

      if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (state == S_PRE)  pre_rem  <= pre_rem - 1'b1;
        if (state == S_POST) post_rem <= post_rem - 1'b1;
        if (state != S_POST) begin
          prev_sample <= bus.sample_in;
          prev_valid  <= 1'b1;
        end
      end

      if (trig_hit) begin
        start_ptr <= start_calc;
        triggered <= 1'b1;
        post_rem  <= PTR_MAX - p_eff;
      end

      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end else if ((state_nx == S_DONE) && (state != S_DONE)) begin
        rd_ptr <= trig_hit ? start_calc : start_ptr;
      end
    end
  end

  // Capture RAM: no reset, one write port and one registered read port
  always_ff @(posedge adc_clk) begin
    if (we)    mem[wr_ptr] <= bus.sample_in;
    if (rd_ok) ram_q       <= mem[rd_ptr];
  end

endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer: a history-based model of the capture frame is
// compared against the DUT every cycle, plus literal checks on each scenario.
module tb_capture_buffer;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              adc_clk = 1'b0;
  logic              reset = 1'b1;
  logic              arm = 1'b0;
  logic              force_trig = 1'b0;
  logic [DATA_W-1:0] trig_level = '0;
  logic              trig_rising = 1'b1;
  logic [ADDR_W-1:0] pre_count = '0;
  logic              busy;
  logic              triggered;
  logic              done;

  capture_buffer_if #(.DATA_W(DATA_W)) bus ();

  capture_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .adc_clk     (adc_clk),
    .reset       (reset),
    .bus         (bus),
    .arm         (arm),
    .force_trig  (force_trig),
    .trig_level  (trig_level),
    .trig_rising (trig_rising),
    .pre_count   (pre_count),
    .busy        (busy),
    .triggered   (triggered),
    .done        (done)
  );

  always #5 adc_clk = ~adc_clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Model: every sample stored since arm, index of the trigger sample in that history,
  // and the frame is the DEPTH samples starting p before the trigger.
  int hist[$];
  bit m_armed     = 1'b0;
  int m_trig_idx  = -1;
  int m_p         = 0;
  int m_rd_cnt    = 0;
  int m_acc_cycle = -10;
  int m_acc_data  = 0;
  int m_rd_data   = 0;
  int cyc         = 0;
  bit chk_en      = 1'b0;

  function automatic bit m_done();
    return m_armed && (m_trig_idx >= 0) && ((hist.size() - 1 - m_trig_idx) == DEPTH - 1 - m_p);
  endfunction

  function automatic bit m_busy();
    return m_armed && !m_done();
  endfunction

  function automatic bit m_waiting();
    return m_busy() && (m_trig_idx < 0) && (hist.size() >= m_p);
  endfunction

  always @(posedge adc_clk) begin
    int t;
    int s;
    int q;
    bit hit;
    t = cyc;
    if (reset) begin
      m_armed     = 1'b0;
      hist.delete();
      m_trig_idx  = -1;
      m_p         = 0;
      m_rd_cnt    = 0;
      m_acc_cycle = -10;
      m_rd_data   = 0;
    end else begin
      if (t == m_acc_cycle + 1) m_rd_data = m_acc_data;
      if (arm && !m_busy()) begin
        m_armed    = 1'b1;
        hist.delete();
        m_trig_idx = -1;
        m_p        = int'(pre_count);
        m_rd_cnt   = 0;
      end else if (m_busy() && bus.sample_stb) begin
        s = int'(bus.sample_in);
        if (m_waiting()) begin
          hit = force_trig;
          if (hist.size() > 0) begin
            q = hist[hist.size() - 1];
            if (trig_rising) hit = hit || ((q < int'(trig_level)) && (s >= int'(trig_level)));
            else             hit = hit || ((q > int'(trig_level)) && (s <= int'(trig_level)));
          end
          if (hit) m_trig_idx = hist.size();
        end
        hist.push_back(s);
      end else if (m_done() && bus.rd_req && (t != m_acc_cycle + 1)) begin
        m_acc_cycle = t;
        m_acc_data  = hist[m_trig_idx - m_p + (m_rd_cnt % DEPTH)];
        m_rd_cnt++;
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge adc_clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_busy()));
      chk("triggered", int'(triggered), int'(m_armed && (m_trig_idx >= 0)));
      chk("done", int'(done), int'(m_done()));
      chk("rd_valid", int'(bus.rd_valid), int'(cyc == m_acc_cycle + 2));
      chk("rd_data", int'(bus.rd_data), m_rd_data);
    end
  end

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic strobe(input int v, input int gap);
    bus.sample_in  = DATA_W'(v);
    bus.sample_stb = 1'b1;
    tick();
    bus.sample_stb = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic do_read(input string name, input int exp);
    int k;
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    k = 1;
    while (!bus.rd_valid && (k < 8)) begin
      tick();
      k++;
    end
    chk({name, " latency"}, k, 2);
    chk({name, " data"}, int'(bus.rd_data), exp);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.sample_in  = '0;
    bus.sample_stb = 1'b0;
    bus.rd_req     = 1'b0;
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset triggered", int'(triggered), 0);
    chk("reset rd_data", int'(bus.rd_data), 0);

    // Reset in the middle of POST
    pre_count = 4'd2; trig_level = 8'd5; trig_rising = 1'b1;
    pulse_arm();
    for (int v = 0; v <= 8; v++) strobe(v, 1);
    chk("t1 triggered before reset", int'(triggered), 1);
    chk("t1 busy before reset", int'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t1 busy after reset", int'(busy), 0);
    chk("t1 triggered after reset", int'(triggered), 0);
    chk("t1 done after reset", int'(done), 0);
    chk("t1 rd_valid after reset", int'(bus.rd_valid), 0);

    // Rising trigger, sparse strobes
    pre_count = 4'd4; trig_level = 8'd10; trig_rising = 1'b1;
    pulse_arm();
    for (int v = 0; v <= 21; v++) strobe(v, 3);
    chk("t2 done", int'(done), 1);
    chk("t2 model trigger sample", hist[m_trig_idx], 10);
    strobe(99, 1);
    strobe(98, 1);
    chk("t2 model ignores strobes in done", hist.size(), 22);
    for (int i = 0; i < 16; i++) do_read("t2 read", 6 + i);
    do_read("t2 17th read", 6);
    n = 0;
    bus.rd_req = 1'b1;
    repeat (4) begin
      tick();
      if (bus.rd_valid) n++;
    end
    bus.rd_req = 1'b0;
    repeat (3) begin
      tick();
      if (bus.rd_valid) n++;
    end
    chk("t2 back-to-back accepted", n, 2);
    chk("t2 back-to-back last data", int'(bus.rd_data), 8);

    // Falling trigger with buffer wrap
    pre_count = 4'd8; trig_level = 8'd100; trig_rising = 1'b0;
    pulse_arm();
    repeat (30) strobe(200, 1);
    for (int v = 199; v >= 93; v--) strobe(v, 1);
    chk("t3 done", int'(done), 1);
    chk("t3 model trigger sample", hist[m_trig_idx], 100);
    for (int i = 0; i < 16; i++) do_read("t3 read", 108 - i);

    // First stored sample cannot edge-trigger
    pre_count = 4'd0; trig_level = 8'd50; trig_rising = 1'b1;
    pulse_arm();
    strobe(60, 2);
    chk("t4 no trigger on first sample", int'(triggered), 0);
    strobe(40, 2);
    chk("t4 no trigger on 40", int'(triggered), 0);
    strobe(55, 2);
    chk("t4 trigger on 55", int'(triggered), 1);
    for (int i = 0; i < 15; i++) strobe(56 + i, 1);
    chk("t4 done", int'(done), 1);
    do_read("t4 first read", 55);

    // force_trig on the very first sample
    force_trig = 1'b1;
    pulse_arm();
    strobe(7, 1);
    force_trig = 1'b0;
    chk("t4 forced trigger", int'(triggered), 1);
    for (int v = 8; v <= 22; v++) strobe(v, 1);
    chk("t4 forced done", int'(done), 1);
    do_read("t4 forced first read", 7);

    // Maximum pre-trigger depth, arm and read ignored while capturing
    pre_count = 4'd15; trig_level = 8'd16; trig_rising = 1'b1;
    pulse_arm();
    for (int v = 1; v <= 15; v++) strobe(v, 1);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    repeat (3) tick();
    pulse_arm();
    chk("t5 arm in wait ignored", int'(busy), 1);
    strobe(16, 1);
    chk("t5 done right after trigger", int'(done), 1);
    chk("t5 busy after trigger", int'(busy), 0);
    do_read("t5 first read", 1);
    do_read("t5 second read", 2);

    // Reset discards a pending read
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("t6 pending read dropped", int'(bus.rd_valid), 0);
    chk("t6 rd_data cleared", int'(bus.rd_data), 0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_buffer.md
Name: capture_buffer

Overview:
- Consumer end of the decimated sample stream.
- Accepts the 8-bit decimated sample and its one-cycle strobe from the acquisition block.
- Runs a pre-trigger ring buffer with level/edge trigger detection, then freezes one full capture.
- Plays the capture back oldest-first to the host-side readout logic through a request/valid handshake.

Parameters:
ADDR_W, 12, buffer address width; DEPTH = 2**ADDR_W samples
DATA_W, 8, sample width

Ports:
adc_clk  in  1  sole clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
sample_in  in  DATA_W  decimated sample
sample_stb  in  1  one-cycle strobe; sample_in valid when high
arm  in  1  one-cycle pulse; starts a capture
force_trig  in  1  level; forces a trigger on the next stored sample while in WAIT
trig_level  in  DATA_W  trigger threshold, unsigned
trig_rising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
pre_count  in  ADDR_W  samples kept before the trigger sample
rd_req  in  1  one-cycle read request
rd_data  out  DATA_W  readout byte
rd_valid  out  1  one-cycle pulse; rd_data valid
busy  out  1  high in PRE, WAIT and POST
triggered  out  1  high from trigger acceptance until the next arm or reset
done  out  1  high in DONE

Behaviour:
- State machine: IDLE, PRE, WAIT, POST, DONE.
- Reset, including mid-capture or mid-read:
  - State goes to IDLE; all pointers and counters clear.
  - Outputs: rd_data=0, rd_valid=0, busy=0, triggered=0, done=0.
  - A pending read is discarded.
- Arm:
  - Accepted in IDLE or DONE only; ignored in PRE, WAIT and POST.
  - On acceptance: wr_ptr=0, stored-count=0, prev_valid=0, triggered=0, then PRE.
  - A sample strobed in the same cycle as an accepted arm is not stored.
- Writes:
  - Occur only in PRE, WAIT and POST, only when sample_stb=1.
  - Write mem[wr_ptr]=sample_in, then wr_ptr increments mod DEPTH and overwrites the oldest entry.
- pre_count clamp: an effective value p = min(pre_count, DEPTH-1) is latched at arm acceptance.
- PRE:
  - Counts stored samples.
  - When the count reaches p, go to WAIT.
  - If p=0, go to WAIT on the cycle after arm with nothing stored.
- WAIT, on each stored sample s with previous stored sample q:
  - rising: q < trig_level and s >= trig_level
  - falling: q > trig_level and s <= trig_level
  - force_trig=1 triggers on the current stored sample unconditionally.
  - The edge trigger requires prev_valid. The first sample stored after arm can only trigger via force_trig.
  - prev_valid is set by any stored sample in PRE or WAIT.
- On trigger:
  - The trigger sample is written.
  - trig_ptr = its address.
  - start_ptr = (trig_ptr - p) mod DEPTH.
  - triggered=1.
  - Go to POST with post_remaining = DEPTH-1-p.
  - If post_remaining = 0 (p = DEPTH-1), go directly to DONE.
- POST: each stored sample decrements post_remaining; on reaching 0 go to DONE.
  - Total frame is exactly DEPTH samples: p pre-trigger, the trigger sample, DEPTH-1-p post-trigger.
- DONE:
  - sample_stb is ignored.
  - rd_ptr = start_ptr on entry.
- Read handshake:
  - rd_req in DONE with no read pending: registered RAM read.
  - rd_data and rd_valid are presented 2 cycles after rd_req (request at cycle n, rd_valid=1 at cycle n+2 for one cycle).
  - rd_ptr increments mod DEPTH per accepted request; after DEPTH reads it returns to start_ptr.
  - rd_req while a read is pending, or outside DONE, is ignored.
  - rd_data holds its value between reads.
- Memory: single simple dual-port synchronous RAM, DEPTH x DATA_W, contents not reset. Read data before the first full capture is undefined and never read out.

Test Plan:
Bench uses ADDR_W=4 (DEPTH=16).
- Reset mid-POST: arm, strobe a ramp, assert reset during POST -> next cycle busy=0, triggered=0, done=0, rd_valid=0; state IDLE; a following arm starts cleanly.
- Rising trigger: p=4, trig_level=10, trig_rising=1, ramp 0,1,2,... one strobe every 3 cycles -> trigger on sample 10, done after sample 21; 16 reads return 6..21 in order, each rd_valid exactly 2 cycles after rd_req.
- Falling trigger with wrap: p=8, trig_level=100, trig_rising=0, 30 samples of 200 then descending 199,198,... -> trigger on 100; readout returns 108..93 with buffer wrap-around handled.
- First-sample rule: p=0, trig_level=50, first stored sample 60 -> no trigger; next sample 40 then 55 -> trigger on 55; with force_trig=1 from arm, trigger on the first sample, readout starts at it.
- Boundaries: pre_count=15 -> done immediately after the trigger sample, first read = oldest of 15 pre-samples. Arm during WAIT -> ignored. rd_req on consecutive cycles -> only every other request accepted. 17th read -> returns the first sample again.
